gs232c_ram_initctl: RTL and testbench

Single-port tag/data RAM front-end that consumes the `index`/`valid` sweep produced by the RAM-init counter. While the sweep is active it drives every RAM entry to `INIT_VALUE`, one entry per cycle. Afterwards it arbitrates core read/write requests onto the RAM port. A 2-entry posted-write buffer with read-after-write forwarding sits in front of the port. It sits between the RAM-init counter and the synchronous-read RAM macro inside the cache/TLB arrays.

---
 rtl/gs232c_ram_initctl_if.sv | 28 ++
 rtl/gs232c_ram_initctl.sv | 120 ++++++++++++
 tb/tb_gs232c_ram_initctl.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gs232c_ram_initctl_if.sv
// rtl/gs232c_ram_initctl_if.sv - core request/response and RAM port bundle
interface gs232c_ram_initctl_if #(
  parameter int N = 6,
  parameter int W = 32
);
  logic         req_valid;
  logic         req_ready;
  logic         req_wr;
  logic [N-1:0] req_addr;
  logic [W-1:0] req_wdata;
  logic         resp_valid;
  logic [W-1:0] resp_rdata;
  logic         ram_en;
  logic         ram_we;
  logic [N-1:0] ram_addr;
  logic [W-1:0] ram_wdata;
  logic [W-1:0] ram_rdata;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, ram_rdata,
    input  req_ready, resp_valid, resp_rdata, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, ram_rdata,
    output req_ready, resp_valid, resp_rdata, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/gs232c_ram_initctl.sv
// rtl/gs232c_ram_initctl.sv - RAM front-end: init sweep, 2-entry posted-write buffer, forwarded reads
module gs232c_ram_initctl #(
  parameter int             N          = 6,
  parameter int             W          = 32,
  parameter logic [W-1:0]   INIT_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N-1:0]          init_index,
  input  logic                  init_valid,
  gs232c_ram_initctl_if.slave   bus,
  output logic                  busy
);

  localparam logic [1:0] P_IDLE  = 2'd0;
  localparam logic [1:0] P_INIT  = 2'd1;
  localparam logic [1:0] P_DRAIN = 2'd2;
  localparam logic [1:0] P_READ  = 2'd3;

  logic [N-1:0] r_addr [2];
  logic [W-1:0] r_data [2];
  logic         r_head;
  logic         r_tail;
  logic [1:0]   r_count;
  logic         r_resp_valid;
  logic         r_fwd_hit;
  logic [W-1:0] r_fwd_data;

  logic         w_ready;
  logic         w_acc;
  logic         w_rd;
  logic         w_wr;
  logic         w_drain;
  logic [1:0]   w_sel;
  logic         w_hit_old;
  logic         w_hit_young;
  logic [W-1:0] w_fwd_data;

  assign w_ready = !reset && !init_valid && (r_count != 2'd2);
  assign w_acc   = bus.req_valid && w_ready;
  assign w_rd    = w_acc && !bus.req_wr;
  assign w_wr    = w_acc && bus.req_wr;

  // Opportunistic drains only use cycles in which no request takes the port,
  // so back-to-back writes can fill the buffer before it forces a drain.
  always_comb begin
    w_sel = P_IDLE;
    if (!reset) begin
      if (init_valid)                          w_sel = P_INIT;
      else if (r_count == 2'd2)                w_sel = P_DRAIN;
      else if (w_rd)                           w_sel = P_READ;
      else if (r_count != 2'd0 && !w_wr)       w_sel = P_DRAIN;
    end
  end

  assign w_drain = (w_sel == P_DRAIN);

  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    case (w_sel)
      P_INIT: begin
        bus.ram_en    = 1'b1;
        bus.ram_we    = 1'b1;
        bus.ram_addr  = init_index;
        bus.ram_wdata = INIT_VALUE;
      end
      P_DRAIN: begin
        bus.ram_en    = 1'b1;
        bus.ram_we    = 1'b1;
        bus.ram_addr  = r_addr[r_head];
        bus.ram_wdata = r_data[r_head];
      end
      P_READ: begin
        bus.ram_en    = 1'b1;
        bus.ram_addr  = bus.req_addr;
      end
      default: begin
      end
    endcase
  end

  // Entry after the head is the younger one and wins when both match.
  assign w_hit_old   = (r_count != 2'd0) && (r_addr[r_head] == bus.req_addr);
  assign w_hit_young = (r_count == 2'd2) && (r_addr[~r_head] == bus.req_addr);
  assign w_fwd_data  = w_hit_young ? r_data[~r_head] : r_data[r_head];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head       <= 1'b0;
      r_tail       <= 1'b0;
      r_count      <= 2'd0;
      r_resp_valid <= 1'b0;
      r_fwd_hit    <= 1'b0;
    end else begin
      if (w_wr)    r_tail <= ~r_tail;
      if (w_drain) r_head <= ~r_head;
      if (w_wr && !w_drain)      r_count <= r_count + 2'd1;
      else if (!w_wr && w_drain) r_count <= r_count - 2'd1;
      r_resp_valid <= w_rd;
      r_fwd_hit    <= w_rd && (w_hit_old || w_hit_young);
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_addr[r_tail] <= bus.req_addr;
      r_data[r_tail] <= bus.req_wdata;
    end
    if (w_rd) r_fwd_data <= w_fwd_data;
  end

  assign bus.req_ready  = w_ready;
  assign bus.resp_valid = !reset && r_resp_valid;
  assign bus.resp_rdata = bus.resp_valid ? (r_fwd_hit ? r_fwd_data : bus.ram_rdata) : '0;
  assign busy           = init_valid || (!reset && (r_count != 2'd0));

endmodule

// File: tb/tb_gs232c_ram_initctl.sv
// tb/tb_gs232c_ram_initctl.sv - randomized self-checking bench for gs232c_ram_initctl
module tb_gs232c_ram_initctl;
  localparam int N  = 6;
  localparam int W  = 32;
  localparam int D  = 1 << N;
  localparam int VW = 5 + N + 2 * W;

  typedef struct packed {
    logic         rst;
    logic         v;
    logic         wr;
    logic [N-1:0] a;
    logic [W-1:0] d;
    logic         cr;
    logic         r;
    logic         cv;
    logic [W-1:0] want;
  } op_t;

  typedef struct packed {
    logic [N-1:0] a;
    logic [W-1:0] d;
  } wr_t;

  logic         clock      = 1'b0;
  logic         reset      = 1'b1;
  logic         init_valid = 1'b0;
  logic [N-1:0] init_index = '0;
  logic         busy;
  logic         preload    = 1'b1;

  gs232c_ram_initctl_if #(.N(N), .W(W)) bus ();

  gs232c_ram_initctl #(.N(N), .W(W), .INIT_VALUE(32'h0)) dut (
    .clock(clock), .reset(reset), .init_index(init_index),
    .init_valid(init_valid), .bus(bus), .busy(busy)
  );

  always #5 clock = ~clock;

  // Synchronous-read RAM macro stand-in
  logic [W-1:0] ram_mem [D];
  logic [W-1:0] gmem [D];
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < D; i++) ram_mem[i] <= gmem[i];
    end else if (bus.ram_en && bus.ram_we) begin
      ram_mem[bus.ram_addr] <= bus.ram_wdata;
    end
    if (bus.ram_en && !bus.ram_we) bus.ram_rdata <= ram_mem[bus.ram_addr];
  end

  wr_t          wq[$];
  logic         m_pend;
  logic [W-1:0] m_data;
  logic         e_ready, e_en, e_we, e_busy, e_resp, e_acc, e_drain, e_init;
  logic [N-1:0] e_addr;
  logic [W-1:0] e_wdata, e_rdata;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic predict();
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    e_drain = 1'b0; e_init = 1'b0;
    e_ready = !reset && !init_valid && (wq.size() < 2);
    e_acc   = bus.req_valid && e_ready;
    e_resp  = !reset && m_pend;
    e_rdata = e_resp ? m_data : '0;
    e_busy  = init_valid || (!reset && wq.size() > 0);
    if (!reset) begin
      if (init_valid) begin
        e_init = 1'b1; e_en = 1'b1; e_we = 1'b1; e_addr = init_index;
      end else if (wq.size() == 2 || (wq.size() > 0 && !e_acc)) begin
        e_drain = 1'b1; e_en = 1'b1; e_we = 1'b1; e_addr = wq[0].a; e_wdata = wq[0].d;
      end else if (e_acc && !bus.req_wr) begin
        e_en = 1'b1; e_addr = bus.req_addr;
      end
    end
  endtask

  task automatic advance();
    logic [W-1:0] rd;
    rd = '0;
    if (reset) begin
      wq.delete();
      m_pend = 1'b0;
    end else begin
      if (e_acc && !bus.req_wr) begin
        rd = gmem[bus.req_addr];
        foreach (wq[i]) if (wq[i].a == bus.req_addr) rd = wq[i].d;
      end
      m_pend = e_acc && !bus.req_wr;
      m_data = rd;
      if (e_init) gmem[init_index] = '0;
      if (e_drain) begin
        gmem[wq[0].a] = wq[0].d;
        void'(wq.pop_front());
      end
      if (e_acc && bus.req_wr) wq.push_back('{a: bus.req_addr, d: bus.req_wdata});
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input op_t o);
    reset         = o.rst;
    bus.req_valid = o.v;
    bus.req_wr    = o.wr;
    bus.req_addr  = o.a;
    bus.req_wdata = o.d;
    predict();
    #1;
  endtask

  function automatic op_t mk(input logic rst, input logic v, input logic wr, input logic [N-1:0] a,
                             input logic [W-1:0] d, input logic cr, input logic r, input logic cv,
                             input logic [W-1:0] want);
    op_t o;
    o.rst = rst; o.v = v; o.wr = wr; o.a = a; o.d = d;
    o.cr = cr; o.r = r; o.cv = cv; o.want = want;
    return o;
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {bus.req_ready, bus.ram_en, bus.ram_we, busy, bus.resp_valid,
            e_en ? bus.ram_addr : {N{1'b0}}, e_we ? bus.ram_wdata : {W{1'b0}},
            e_resp ? bus.resp_rdata : {W{1'b0}}};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {e_ready, e_en, e_we, e_busy, e_resp, e_addr,
            e_we ? e_wdata : {W{1'b0}}, e_resp ? e_rdata : {W{1'b0}}};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(mk(1'b1, 1'b1, 1'(i), 6'h01, 32'h5, 1'b0, 1'b0, 1'b0, '0));
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL reset[%0d]: port %h, want %h", i, obs_vec(), exp_vec());
      end
      n_checks++;
      if (bus.req_ready !== 1'b0 || bus.ram_en !== 1'b0 || bus.resp_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_outputs[%0d]: rdy=%b en=%b rv=%b, want 000", i, bus.req_ready, bus.ram_en, bus.resp_valid);
      end
      advance();
    end
  endtask

  task automatic test_init();
    init_valid = 1'b1;
    for (int i = 0; i < D; i++) begin
      init_index = N'(i);
      drive(mk(1'b0, 1'($urandom), 1'($urandom), N'($urandom), $urandom, 1'b0, 1'b0, 1'b0, '0));
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL init[%0d]: port %h, want %h", i, obs_vec(), exp_vec());
      end
      n_checks++;
      if (bus.ram_addr !== N'(i) || bus.ram_we !== 1'b1 || bus.ram_wdata !== 32'h0 || bus.req_ready !== 1'b0) begin
        n_fail++; $display("FAIL init_sweep[%0d]: addr=%0d we=%b wd=%h rdy=%b, want addr=%0d we=1 wd=0 rdy=0",
                           i, bus.ram_addr, bus.ram_we, bus.ram_wdata, bus.req_ready, i);
      end
      advance();
    end
    init_valid = 1'b0;
    drive(mk(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0));
    n_checks++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL init_done: rdy=%b busy=%b, want rdy=1 busy=0", bus.req_ready, busy);
    end
    advance();
  endtask

  task automatic run_table(input string name, input op_t ops[$], output int accepts);
    accepts = 0;
    foreach (ops[i]) begin
      drive(ops[i]);
      if (bus.req_valid && bus.req_ready) accepts++;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL %s[%0d]: port %h, want %h", name, i, obs_vec(), exp_vec());
      end
      if (ops[i].cr) begin
        n_checks++;
        if (bus.req_ready !== ops[i].r) begin
          n_fail++; $display("FAIL %s_ready[%0d]: got %b, want %b", name, i, bus.req_ready, ops[i].r);
        end
      end
      if (ops[i].cv) begin
        n_checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== ops[i].want) begin
          n_fail++; $display("FAIL %s_resp[%0d]: valid=%b data=%h, want valid=1 data=%h",
                             name, i, bus.resp_valid, bus.resp_rdata, ops[i].want);
        end
      end
      advance();
    end
  endtask

  task automatic test_forward();
    op_t ops[$];
    int  acc;
    ops.push_back(mk(0, 1, 1, 6'h20, 32'hDEADBEEF, 0, 0, 0, '0));
    ops.push_back(mk(0, 1, 0, 6'h20, '0,           0, 0, 0, '0));
    ops.push_back(mk(0, 0, 0, '0,    '0,           0, 0, 1, 32'hDEADBEEF));
    ops.push_back(mk(0, 0, 0, '0,    '0,           0, 0, 0, '0));
    ops.push_back(mk(0, 1, 1, 6'h05, 32'h11,       0, 0, 0, '0));
    ops.push_back(mk(0, 1, 1, 6'h05, 32'h22,       0, 0, 0, '0));
    ops.push_back(mk(0, 1, 0, 6'h05, '0,           1, 0, 0, '0));
    ops.push_back(mk(0, 1, 0, 6'h05, '0,           1, 1, 0, '0));
    ops.push_back(mk(0, 0, 0, '0,    '0,           0, 0, 1, 32'h22));
    ops.push_back(mk(0, 0, 0, '0,    '0,           0, 0, 0, '0));
    ops.push_back(mk(0, 0, 0, '0,    '0,           0, 0, 0, '0));
    run_table("forward", ops, acc);
  endtask

  task automatic test_back_to_back();
    op_t ops[$];
    int  acc;
    ops.push_back(mk(0, 1, 1, 6'h10, 32'hA1, 0, 0, 0, '0));
    ops.push_back(mk(0, 1, 1, 6'h11, 32'hB2, 0, 0, 0, '0));
    ops.push_back(mk(0, 1, 1, 6'h12, 32'hC3, 1, 0, 0, '0));
    ops.push_back(mk(0, 1, 1, 6'h12, 32'hC3, 1, 1, 0, '0));
    for (int i = 0; i < 3; i++) ops.push_back(mk(0, 0, 0, '0, '0, 0, 0, 0, '0));
    ops.push_back(mk(0, 1, 0, 6'h10, '0, 0, 0, 0, '0));
    ops.push_back(mk(0, 1, 0, 6'h11, '0, 0, 0, 1, 32'hA1));
    ops.push_back(mk(0, 1, 0, 6'h12, '0, 0, 0, 1, 32'hB2));
    ops.push_back(mk(0, 0, 0, '0,    '0, 0, 0, 1, 32'hC3));
    run_table("back_to_back", ops, acc);
  endtask

  task automatic test_read_stream();
    op_t ops[$];
    int  acc;
    ops.push_back(mk(0, 1, 1, 6'h30, 32'h1234_0030, 0, 0, 0, '0));
    ops.push_back(mk(0, 1, 1, 6'h31, 32'h1234_0031, 0, 0, 0, '0));
    for (int i = 0; i < 10; i++)
      ops.push_back(mk(0, 1, 0, 6'h30 + N'($urandom_range(0, 3)), '0, 1, (i != 0), 0, '0));
    for (int i = 0; i < 3; i++) ops.push_back(mk(0, 0, 0, '0, '0, 0, 0, 0, '0));
    run_table("read_stream", ops, acc);
    n_checks++;
    if (acc != 11) begin
      n_fail++; $display("FAIL read_stream_rate: accepted %0d requests, want 11", acc);
    end
  endtask

  task automatic test_random();
    op_t ops[$];
    int  acc;
    for (int i = 0; i < 400; i++)
      ops.push_back(mk(0, ($urandom_range(0, 3) != 0), 1'($urandom), N'($urandom_range(0, 7)),
                       $urandom, 0, 0, 0, '0));
    for (int i = 0; i < 4; i++) ops.push_back(mk(0, 0, 0, '0, '0, 0, 0, 0, '0));
    run_table("random", ops, acc);
    n_checks++;
    begin
      int bad = 0;
      for (int i = 0; i < D; i++) if (ram_mem[i] !== gmem[i]) bad++;
      if (bad != 0 || wq.size() != 0) begin
        n_fail++; $display("FAIL ram_contents: %0d entries differ, %0d writes pending, want 0 and 0", bad, wq.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    op_t ops[$];
    int  acc;
    ops.push_back(mk(0, 1, 1, 6'h09, 32'h99, 0, 0, 0, '0));
    ops.push_back(mk(0, 1, 0, 6'h0A, '0,     0, 0, 0, '0));
    ops.push_back(mk(1, 1, 1, 6'h0B, 32'h77, 1, 0, 0, '0));
    ops.push_back(mk(0, 0, 0, '0,    '0,     0, 0, 0, '0));
    ops.push_back(mk(0, 1, 1, 6'h03, 32'h33, 0, 0, 0, '0));
    ops.push_back(mk(0, 1, 1, 6'h04, 32'h44, 0, 0, 0, '0));
    ops.push_back(mk(1, 0, 0, '0,    '0,     0, 0, 0, '0));
    run_table("reset_mid", ops, acc);
    init_valid = 1'b1;
    for (int i = 0; i < D; i++) begin
      init_index = N'(i);
      drive(mk(0, 0, 0, '0, '0, 0, 0, 0, '0));
      n_checks++;
      if (obs_vec() !== exp_vec() || bus.ram_addr !== N'(i) || bus.ram_wdata !== 32'h0) begin
        n_fail++; $display("FAIL resweep[%0d]: port %h addr=%0d, want %h addr=%0d", i, obs_vec(), bus.ram_addr, exp_vec(), i);
      end
      advance();
    end
    init_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(mk(0, 0, 0, '0, '0, 0, 0, 0, '0));
      n_checks++;
      if (bus.ram_en !== 1'b0 || busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_dropped[%0d]: en=%b busy=%b rv=%b, want 000", i, bus.ram_en, busy, bus.resp_valid);
      end
      advance();
    end
    n_checks++;
    begin
      int bad = 0;
      for (int i = 0; i < D; i++) if (ram_mem[i] !== 32'h0) bad++;
      if (bad != 0) begin
        n_fail++; $display("FAIL resweep_contents: %0d entries nonzero, want 0", bad);
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    m_pend        = 1'b0;
    m_data        = '0;
    for (int i = 0; i < D; i++) gmem[i] = $urandom;
    @(negedge clock);
    preload = 1'b0;
    test_reset();
    test_init();
    test_forward();
    test_back_to_back();
    test_read_stream();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
